ffdiv_param: RTL and testbench

Parametrised iterative IEEE-754-style floating-point divider, successor to the fixed 32-bit ffdiv. It generalises the exponent and fraction widths and adds a valid/ready handshake on both sides with output back-pressure. It adds round-to-nearest-even, subnormal-input normalisation and an optional early-termination mode. It sits behind the ffdiv bus interface as the arithmetic core and reports the same 5-bit flag vector plus the iteration count.

---
 rtl/ffdiv_pkg.sv | 40 ++++
 rtl/ffdiv_lzc.sv | 23 ++
 rtl/ffdiv_param.sv | 240 ++++++++++++++++++++++++
 tb/tb_ffdiv_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ffdiv_pkg.sv
// Shared types and helpers for the parametrised floating-point divider.
// Flag bit positions, FSM states, operand classes and the operand classifier.
package ffdiv_pkg;

  localparam int unsigned FLAG_W    = 5;
  localparam int unsigned FLAG_NANF = 4;
  localparam int unsigned FLAG_OVF  = 3;
  localparam int unsigned FLAG_INF  = 2;
  localparam int unsigned FLAG_UF   = 1;
  localparam int unsigned FLAG_ZF   = 0;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIVIDE,
    ROUND,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } cls_e;

  // Field summaries keep the classifier independent of EXP_W/FRAC_W.
  function automatic cls_e classify(input logic exp_ones, input logic exp_zero,
                                    input logic frac_zero, input logic frac_msb);
    cls_e c;
    if (exp_zero)       c = frac_zero ? CLS_ZERO : CLS_SUB;
    else if (!exp_ones) c = CLS_NORM;
    else if (frac_zero) c = CLS_INF;
    else                c = frac_msb ? CLS_QNAN : CLS_SNAN;
    return c;
  endfunction

endpackage

// File: rtl/ffdiv_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module ffdiv_lzc #(
  parameter int unsigned WIDTH = 24,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [CNT_W-1:0] lzc_c
);

  logic found;

  always_comb begin
    lzc_c = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_vec[i]) begin
        lzc_c = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ffdiv_param.sv
// Iterative restoring floating-point divider with RNE rounding and valid/ready handshakes.
// Define FFDIV_EARLY_TERM_EN to stop iterating once the partial remainder reaches zero.
module ffdiv_param
  import ffdiv_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  localparam int unsigned W     = 1 + EXP_W + FRAC_W,
  localparam int unsigned Q_W   = FRAC_W + 3,
  localparam int unsigned CNT_W = $clog2(Q_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      operand1,
  input  logic [W-1:0]      operand2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      result,
  output logic [FLAG_W-1:0] flag,
  output logic [CNT_W-1:0]  itr_count
);

  localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int unsigned M_W  = FRAC_W + 1;
  localparam int unsigned MR_W = M_W + 1;
  localparam int unsigned R_W  = M_W + 1;
  localparam int unsigned E_W  = EXP_W + 2;
  localparam int unsigned LZ_W = $clog2(M_W + 1);

  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'(2 ** EXP_W - 1);
  localparam logic [W-1:0] QBIT  = W'(1) << (FRAC_W - 1);
  localparam logic [W-1:0] CANON = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};

  state_e                  state_q, state_d;
  logic [W-1:0]            op1_q, op1_d, op2_q, op2_d;
  logic signed [E_W-1:0]   e_q, e_d;
  logic                    sign_q, sign_d;
  logic [R_W-1:0]          r_q, r_d;
  logic [M_W-1:0]          d_q, d_d;
  logic [Q_W-1:0]          q_q, q_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]            result_q, result_d;
  logic [FLAG_W-1:0]       flag_q, flag_d;
  logic [CNT_W-1:0]        itr_q, itr_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;

  logic                    s1, s2;
  logic [EXP_W-1:0]        x1, x2;
  logic [FRAC_W-1:0]       f1, f2;
  cls_e                    c1, c2;
  logic [LZ_W-1:0]         lz1, lz2;
  logic                    nan1, nan2;

  logic signed [E_W-1:0]   ea, eb, en, ef;
  logic [M_W-1:0]          ma, mb, mant;
  logic [MR_W-1:0]         mant_r;
  logic [R_W-1:0]          rem;
  logic [Q_W-1:0]          qn;
  logic                    ge, last, rnd;

  assign {s1, x1, f1} = op1_q;
  assign {s2, x2, f2} = op2_q;
  assign c1   = classify(&x1, ~|x1, ~|f1, f1[FRAC_W-1]);
  assign c2   = classify(&x2, ~|x2, ~|f2, f2[FRAC_W-1]);
  assign nan1 = (c1 == CLS_QNAN) || (c1 == CLS_SNAN);
  assign nan2 = (c2 == CLS_QNAN) || (c2 == CLS_SNAN);

  ffdiv_lzc #(.WIDTH(M_W)) u_lzc1 (.in_vec({1'b0, f1}), .lzc_c(lz1));
  ffdiv_lzc #(.WIDTH(M_W)) u_lzc2 (.in_vec({1'b0, f2}), .lzc_c(lz2));

  // Next-state and datapath for the whole operation sequence.
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    e_d      = e_q;
    sign_d   = sign_q;
    r_d      = r_q;
    d_d      = d_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;
    itr_d    = itr_q;
    ea       = '0;
    eb       = '0;
    en       = '0;
    ef       = '0;
    ma       = '0;
    mb       = '0;
    mant     = '0;
    mant_r   = '0;
    rem      = '0;
    qn       = '0;
    ge       = 1'b0;
    last     = 1'b0;
    rnd      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op1_d   = operand1;
          op2_d   = operand2;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        sign_d = s1 ^ s2;
        ea     = (c1 == CLS_SUB) ? (E_ONE - E_W'(lz1)) : E_W'(x1);
        eb     = (c2 == CLS_SUB) ? (E_ONE - E_W'(lz2)) : E_W'(x2);
        ma     = (c1 == CLS_SUB) ? ({1'b0, f1} << lz1) : {1'b1, f1};
        mb     = (c2 == CLS_SUB) ? ({1'b0, f2} << lz2) : {1'b1, f2};
        e_d    = ea - eb + E_BIAS;
        r_d    = R_W'(ma);
        d_d    = mb;
        q_d    = '0;
        cnt_d  = '0;
        itr_d  = '0;
        flag_d = '0;
        state_d = DONE;
        if (nan1) begin
          result_d = op1_q | QBIT;
          flag_d[FLAG_NANF] = 1'b1;
        end else if (nan2) begin
          result_d = op2_q | QBIT;
          flag_d[FLAG_NANF] = 1'b1;
        end else if ((c1 == CLS_ZERO && c2 == CLS_ZERO) || (c1 == CLS_INF && c2 == CLS_INF)) begin
          result_d = CANON;
          flag_d[FLAG_NANF] = 1'b1;
        end else if (c2 == CLS_ZERO || c1 == CLS_INF) begin
          result_d = {s1 ^ s2, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          flag_d[FLAG_INF] = 1'b1;
        end else if (c1 == CLS_ZERO || c2 == CLS_INF) begin
          result_d = {s1 ^ s2, {(EXP_W + FRAC_W){1'b0}}};
          flag_d[FLAG_ZF] = 1'b1;
        end else begin
          state_d = DIVIDE;
        end
      end

      // One restoring step per cycle; quotient bits fill MSB first.
      DIVIDE: begin
        ge    = (r_q >= R_W'(d_q));
        rem   = ge ? (r_q - R_W'(d_q)) : r_q;
        q_d   = q_q | (Q_W'(ge) << (CNT_W'(Q_W - 1) - cnt_q));
        r_d   = rem << 1;
        cnt_d = cnt_q + CNT_W'(1);
        last  = (cnt_q == CNT_W'(Q_W - 1));
`ifdef FFDIV_EARLY_TERM_EN
        if (rem == '0) last = 1'b1;
`else
        if (rem == '0) last = last;
`endif
        if (last) begin
          itr_d   = cnt_d;
          state_d = ROUND;
        end
      end

      // Normalise, round to nearest even, then range-check the exponent.
      ROUND: begin
        qn     = q_q[Q_W-1] ? q_q : (q_q << 1);
        en     = q_q[Q_W-1] ? e_q : (e_q - E_ONE);
        mant   = qn[Q_W-1:2];
        rnd    = qn[1] & (qn[0] | (|r_q) | mant[0]);
        mant_r = {1'b0, mant} + MR_W'(rnd);
        ef     = mant_r[M_W] ? (en + E_ONE) : en;
        flag_d = '0;
        if (en[E_W-1] || (en == '0)) begin
          result_d = {sign_q, {(EXP_W + FRAC_W){1'b0}}};
          flag_d[FLAG_UF] = 1'b1;
          flag_d[FLAG_ZF] = 1'b1;
        end else if (ef >= E_MAX) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          flag_d[FLAG_OVF] = 1'b1;
          flag_d[FLAG_INF] = 1'b1;
        end else begin
          result_d = {sign_q, ef[EXP_W-1:0], mant_r[FRAC_W-1:0]};
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      e_q         <= '0;
      sign_q      <= 1'b0;
      r_q         <= '0;
      d_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      flag_q      <= '0;
      itr_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      r_q         <= r_d;
      d_q         <= d_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      itr_q       <= itr_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag      = flag_q;
  assign itr_count = itr_q;

endmodule

// File: tb/tb_ffdiv_param.sv
// Scoreboard bench for ffdiv_param: directed operands, queued expectations, decoupled monitor.
module tb_ffdiv_param;

`ifdef FFDIV_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flag;
  logic [4:0]  itr_count;

  ffdiv_param #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag      (flag),
    .itr_count (itr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
    int          itr;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  bit   prev_ov  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, payload on each transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: result 0x%0h with empty scoreboard", result);
      end else begin
        if (!prev_ov)
          chk($sformatf("latency %h/%h", exp_q[0].a, exp_q[0].b), 32'(cyc - last_acc), 32'(exp_q[0].lat));
        if (out_ready) begin
          e = exp_q.pop_front();
          chk($sformatf("result %h/%h", e.a, e.b), result, e.res);
          chk($sformatf("flag %h/%h", e.a, e.b), 32'(flag), 32'(e.flg));
          chk($sformatf("itr_count %h/%h", e.a, e.b), 32'(itr_count), 32'(e.itr));
        end
      end
    end
    prev_ov = out_valid && !rst;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input logic [4:0] flg, input int itr);
    int n;
    exp_q.push_back('{a: a, b: b, res: res, flg: flg, itr: itr, lat: (itr == 0) ? 2 : itr + 3});
    @(posedge clk); #1;
    in_valid = 1'b1;
    operand1 = a;
    operand2 = b;
    for (n = 0; n < 400 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout %h/%h: in_ready=%0b, expected 1", a, b, in_ready);
    end
    last_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    operand1  = '0;
    operand2  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result",    result,         32'd0);
    chk("reset_flag",      32'(flag),      32'd0);
    chk("reset_itr",       32'(itr_count), 32'd0);
    rst = 1'b0;

    // Back-to-back issues also exercise holding in_valid while the core is busy.
    issue(32'h40A00000, 32'h40000000, 32'h40200000, 5'b00000, ET ? 3 : 26);
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00000, 26);
    issue(32'hC0A00000, 32'h40000000, 32'hC0200000, 5'b00000, ET ? 3 : 26);
    issue(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00000, 26);
    issue(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b01100, ET ? 24 : 26);
    issue(32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, ET ? 1 : 26);
    issue(32'h00400000, 32'h3F000000, 32'h00800000, 5'b00000, ET ? 1 : 26);
    issue(32'h7F800001, 32'h7FC00000, 32'h7FC00001, 5'b10000, 0);
    issue(32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 0);
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b00100, 0);
    issue(32'h80000000, 32'h40A00000, 32'h80000000, 5'b00001, 0);
    issue(32'h3F800000, 32'hFF800001, 32'hFFC00001, 5'b10000, 0);
    issue(32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 0);
    issue(32'hC0400000, 32'h7F800000, 32'h80000000, 5'b00001, 0);
    wait_drain();

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00000, 26);
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("hold_reach_valid", 32'(out_valid), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result",    result,         32'h3EAAAAAB);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of DIVIDE discards the operation.
    issue(32'h40A00000, 32'h40000000, 32'h40200000, 5'b00000, ET ? 3 : 26);
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_result",    result,         32'd0);
    chk("midrst_itr",       32'(itr_count), 32'd0);
    rst = 1'b0;
    issue(32'h40A00000, 32'h40000000, 32'h40200000, 5'b00000, ET ? 3 : 26);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
